// File: rtl/pool_window_gen_pkg.sv
// pool_window_gen_pkg: shared geometry defaults and sizing helpers for the pool window path.
// Pairs are packed {col c+1, col c}, so the low half is always the left pixel.
package pool_window_gen_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int LENET_C1_W = 28;
    localparam int LENET_C1_H = 28;
    localparam int LENET_C3_W = 10;
    localparam int LENET_C3_H = 10;
    localparam int DEF_IMG_W  = LENET_C1_W;
    localparam int DEF_IMG_H  = LENET_C1_H;

    function automatic int pair_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int half_up(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: simple dual-port pair RAM holding one top row of packed pixel pairs.
// Synchronous write, registered read, no reset on storage or read data.
module pool_line_buf
    import pool_window_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 14,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_wr_addr] <= i_wr_data;
        r_rd <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd;
endmodule

// File: rtl/pool_window_gen.sv
// pool_window_gen: turns a raster pixel stream into 2x2 windows (A = top pair, B = bottom pair)
// with a one-cycle max_en strobe for the max-pool unit.
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     in_pix,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  max_en,
    output logic [2*DATA_W-1:0]   A,
    output logic [2*DATA_W-1:0]   B,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int PW    = pair_w(DATA_W);
    localparam int DEPTH = half_up(IMG_W);
    localparam int AW    = addr_w(DEPTH);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [DATA_W-1:0] r_pend;
    logic              r_busy;
    logic              r_max_en;
    logic              r_done;
    logic [PW-1:0]     r_a;
    logic [PW-1:0]     r_b;
    logic              w_acc;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [PW-1:0]     w_pair;
    logic [PW-1:0]     w_rd_data;

    assign w_acc      = in_valid && r_busy;
    assign w_last_col = r_col == CW'(IMG_W - 1);
    assign w_last_row = r_row == RW'(IMG_H - 1);
    assign w_pair     = {in_pix, r_pend};
    // Read address follows col every cycle, so the top pair is ready by the odd column.
    assign w_addr     = AW'(r_col >> 1);
    assign w_we       = w_acc && r_col[0] && !r_row[0];

    pool_line_buf #(
        .WIDTH (PW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line_buf (
        .i_clk     (clk),
        .i_we      (w_we),
        .i_wr_addr (w_addr),
        .i_wr_data (w_pair),
        .i_rd_addr (w_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_pend   <= '0;
            r_busy   <= 1'b0;
            r_max_en <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_max_en <= 1'b0;
            r_done   <= 1'b0;
            if (start && !r_busy) begin
                r_col  <= '0;
                r_row  <= '0;
                r_busy <= 1'b1;
            end else if (w_acc) begin
                if (!r_col[0]) r_pend <= in_pix;
                if (r_col[0] && r_row[0]) begin
                    r_max_en <= 1'b1;
                    r_a      <= w_rd_data;
                    r_b      <= w_pair;
                end
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                if (w_last_col) begin
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                    if (w_last_row) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign in_ready   = r_busy;
    assign busy       = r_busy;
    assign max_en     = r_max_en;
    assign frame_done = r_done;
    assign A          = r_a;
    assign B          = r_b;
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: drives a 4x4 and a 5x3 instance from one shared pixel stream and checks
// every cycle against a pixel-count model plus frame-level window lists.
module tb_pool_window_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_pix = '0;
    logic        start_i [2];
    logic        busy_o  [2];
    logic        rdy_o   [2];
    logic        en_o    [2];
    logic        done_o  [2];
    logic [31:0] a_o     [2];
    logic [31:0] b_o     [2];

    int          total = 0;
    int          bad = 0;
    logic        m_busy [2];
    logic        m_en   [2];
    logic        m_done [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    int          m_cnt  [2];
    logic [15:0] img    [2][16];
    logic [63:0] win_q  [2][$];
    logic [15:0] pix    [$];

    logic [31:0] t1_a [4] = '{32'h0001_0000, 32'h0003_0002, 32'h0009_0008, 32'h000b_000a};
    logic [31:0] t1_b [4] = '{32'h0005_0004, 32'h0007_0006, 32'h000d_000c, 32'h000f_000e};
    logic [15:0] t1_m [4] = '{16'd5, 16'd7, 16'd13, 16'd15};

    always #5 clk = ~clk;

    pool_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut44 (
        .clk(clk), .rst(rst), .start(start_i[0]), .in_pix(in_pix), .in_valid(in_valid),
        .in_ready(rdy_o[0]), .max_en(en_o[0]), .A(a_o[0]), .B(b_o[0]),
        .busy(busy_o[0]), .frame_done(done_o[0])
    );

    pool_window_gen #(.DATA_W(16), .IMG_W(5), .IMG_H(3)) u_dut53 (
        .clk(clk), .rst(rst), .start(start_i[1]), .in_pix(in_pix), .in_valid(in_valid),
        .in_ready(rdy_o[1]), .max_en(en_o[1]), .A(a_o[1]), .B(b_o[1]),
        .busy(busy_o[1]), .frame_done(done_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] max4(input logic [63:0] w);
        logic signed [15:0] m;
        m = w[15:0];
        for (int i = 1; i < 4; i++)
            if ($signed(w[16*i +: 16]) > m) m = w[16*i +: 16];
        return m;
    endfunction

    task automatic step(input int s);
        int w, h, k;
        w = s ? 5 : 4;
        h = s ? 3 : 4;
        if (rst) begin
            m_busy[s] = 1'b0; m_en[s] = 1'b0; m_done[s] = 1'b0;
            m_a[s] = '0; m_b[s] = '0; m_cnt[s] = 0;
        end
        chk($sformatf("busy%0d", s), busy_o[s], m_busy[s]);
        chk($sformatf("ready%0d", s), rdy_o[s], m_busy[s]);
        chk($sformatf("max_en%0d", s), en_o[s], m_en[s]);
        chk($sformatf("done%0d", s), done_o[s], m_done[s]);
        chk($sformatf("A%0d", s), a_o[s], m_a[s]);
        chk($sformatf("B%0d", s), b_o[s], m_b[s]);
        if (en_o[s] === 1'b1) win_q[s].push_back({a_o[s], b_o[s]});
        if (!rst) begin
            m_en[s] = 1'b0;
            m_done[s] = 1'b0;
            if (m_busy[s] && in_valid) begin
                k = m_cnt[s];
                img[s][k] = in_pix;
                if ((k / w) % 2 == 1 && (k % w) % 2 == 1) begin
                    m_en[s] = 1'b1;
                    m_a[s] = {img[s][k-w], img[s][k-w-1]};
                    m_b[s] = {in_pix, img[s][k-1]};
                end
                if (k == w * h - 1) begin
                    m_busy[s] = 1'b0;
                    m_done[s] = 1'b1;
                end
                m_cnt[s]++;
            end else if (start_i[s] && !m_busy[s]) begin
                m_busy[s] = 1'b1;
                m_cnt[s] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        step(0);
        step(1);
    end

    task automatic load_seq(input int n);
        pix.delete();
        for (int i = 0; i < n; i++) pix.push_back(16'(i));
    endtask

    task automatic send_frame(input int s, input int gap, input bit poke);
        win_q[s].delete();
        @(posedge clk); #1 start_i[s] = 1'b1;
        @(posedge clk); #1 start_i[s] = 1'b0;
        for (int k = 0; k < pix.size(); k++) begin
            for (int g = 0; g < 4 && gap > 0 && $urandom_range(99) < gap; g++) begin
                in_valid = 1'b0;
                in_pix = 16'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_pix = pix[k];
            start_i[s] = poke && (k == 5 || k == pix.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start_i[s] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_t1(input string t);
        chk({t, "_n"}, win_q[0].size(), 4);
        for (int i = 0; i < 4 && i < win_q[0].size(); i++) begin
            chk($sformatf("%s_a%0d", t, i), win_q[0][i][63:32], t1_a[i]);
            chk($sformatf("%s_b%0d", t, i), win_q[0][i][31:0], t1_b[i]);
            chk($sformatf("%s_max%0d", t, i), max4(win_q[0][i]), t1_m[i]);
        end
    endtask

    task automatic check_frame(input string t, input int s);
        int w, h, n, base;
        w = s ? 5 : 4;
        h = s ? 3 : 4;
        n = (w / 2) * (h / 2);
        chk({t, "_n"}, win_q[s].size(), n);
        for (int i = 0; i < n && i < win_q[s].size(); i++) begin
            base = (i / (w / 2)) * 2 * w + (i % (w / 2)) * 2;
            chk($sformatf("%s_a%0d", t, i), win_q[s][i][63:32], {pix[base+1], pix[base]});
            chk($sformatf("%s_b%0d", t, i), win_q[s][i][31:0], {pix[base+w+1], pix[base+w]});
        end
    endtask

    initial begin
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        load_seq(16);
        send_frame(0, 0, 1'b0);
        check_t1("t1");

        pix[0] = 16'h8000; pix[1] = 16'hFFFF; pix[4] = 16'h0001; pix[5] = 16'h7FFF;
        send_frame(0, 0, 1'b0);
        chk("t2_n", win_q[0].size(), 4);
        chk("t2_a", win_q[0][0][63:32], 32'hFFFF_8000);
        chk("t2_b", win_q[0][0][31:0], 32'h7FFF_0001);
        chk("t2_max", max4(win_q[0][0]), 16'h7FFF);

        load_seq(16);
        send_frame(0, 50, 1'b0);
        check_t1("t3");

        load_seq(15);
        send_frame(1, 0, 1'b0);
        chk("t4_n", win_q[1].size(), 2);
        chk("t4_a0", win_q[1][0][63:32], 32'h0001_0000);
        chk("t4_b0", win_q[1][0][31:0], 32'h0006_0005);
        chk("t4_a1", win_q[1][1][63:32], 32'h0003_0002);
        chk("t4_b1", win_q[1][1][31:0], 32'h0008_0007);

        load_seq(16);
        win_q[0].delete();
        @(posedge clk); #1 start_i[0] = 1'b1;
        @(posedge clk); #1 start_i[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_pix = pix[k];
            @(posedge clk); #1;
        end
        in_pix = pix[5];
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy_o[0], 1'b0);
        chk("t5_en", en_o[0], 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_nowin", win_q[0].size(), 0);
        send_frame(0, 0, 1'b0);
        check_t1("t5");

        send_frame(0, 0, 1'b1);
        check_t1("t6");

        for (int f = 0; f < 6; f++) begin
            pix.delete();
            for (int i = 0; i < ((f % 2) ? 15 : 16); i++) pix.push_back(16'($urandom));
            send_frame(f % 2, 30, f >= 3);
            check_frame($sformatf("rnd%0d", f), f % 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
